// File: rtl/video_in_dma_if.sv
// rtl/video_in_dma_if.sv - Wishbone master bundle for the video input DMA write port.
interface video_in_dma_if;
   logic        stb;
   logic        cyc;
   logic        lock;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat;
   logic        ack;
   logic        err;

   modport master (output stb, cyc, lock, we, sel, adr, dat, input ack, err);
   modport slave  (input stb, cyc, lock, we, sel, adr, dat, output ack, err);
endinterface

// File: rtl/video_in_dma.sv
// rtl/video_in_dma.sv - Streams FIFO pixel words into RAM frame buffers over Wishbone.
// Bursts of NB_PACK pixels hold CYC; a frame raises a timed interrupt, optionally ping-ponging buffers.
module video_in_dma #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int NB_PACK = 16,
   parameter int STRIDE  = 640,
   parameter int IRQ_LEN = 3
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic [31:0] cfg_ctrl,
   input  logic [31:0] cfg_addr0,
   input  logic [31:0] cfg_addr1,
   input  logic        nb_pack_available,
   input  logic [31:0] data_fifo,
   output logic        r_ack,
   output logic        interrupt,
   output logic        err_irq,
   output logic        buf_idx,
   output logic        busy,
   output logic        new_addr,
   output logic        p_wb_STB_O,
   output logic        p_wb_CYC_O,
   output logic        p_wb_LOCK_O,
   output logic        p_wb_WE_O,
   output logic [3:0]  p_wb_SEL_O,
   output logic [31:0] p_wb_ADR_O,
   output logic [31:0] p_wb_DAT_O,
   input  logic        p_wb_ACK_I,
   input  logic        p_wb_ERR_I
);
   localparam int COL_W  = $clog2(WIDTH + 1);
   localparam int LINE_W = $clog2(HEIGHT + 1);
   localparam int BW_W   = $clog2(NB_PACK / 4 + 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 4);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);
   localparam logic [BW_W-1:0]   BW_LAST   = BW_W'(NB_PACK / 4 - 1);
   localparam logic [3:0]        IRQ_LOAD  = 4'(IRQ_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_PACK, S_WRITE, S_BREAK, S_FRAME_DONE, S_ERROR
   } state_t;

   state_t             state_q, state_d;
   logic               start_q;
   logic [31:0]        base0_q, base0_d, base1_q, base1_d;
   logic               pp_q, pp_d, buf_q, buf_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [31:0]        lbase_q, lbase_d;
   logic [BW_W-1:0]    bw_q, bw_d;
   logic [3:0]         irq_q, irq_d;
   logic               abort;
   logic [31:0]        wr_adr;
   logic               unused_ctrl;

   assign abort       = cfg_ctrl[2];
   assign unused_ctrl = ^cfg_ctrl[31:3];
   assign new_addr    = cfg_ctrl[0] & ~start_q;

   // line*STRIDE is carried in lbase_q, bumped by STRIDE at each line end
   assign wr_adr      = (buf_q ? base1_q : base0_q) + lbase_q + 32'(col_q);

   assign p_wb_STB_O  = (state_q == S_WRITE);
   assign p_wb_CYC_O  = (state_q == S_WRITE) || (state_q == S_BREAK);
   assign p_wb_ADR_O  = (state_q == S_WRITE) ? wr_adr : 32'h0;
   assign p_wb_DAT_O  = data_fifo;
   assign p_wb_SEL_O  = 4'hF;
   assign p_wb_WE_O   = 1'b1;
   assign p_wb_LOCK_O = 1'b0;
   assign interrupt   = (state_q == S_FRAME_DONE);
   assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
   assign buf_idx     = buf_q;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         base0_q <= '0;
         base1_q <= '0;
         pp_q    <= 1'b0;
         buf_q   <= 1'b0;
         col_q   <= '0;
         line_q  <= '0;
         lbase_q <= '0;
         bw_q    <= '0;
         irq_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= cfg_ctrl[0];
         base0_q <= base0_d;
         base1_q <= base1_d;
         pp_q    <= pp_d;
         buf_q   <= buf_d;
         col_q   <= col_d;
         line_q  <= line_d;
         lbase_q <= lbase_d;
         bw_q    <= bw_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base0_d = base0_q;
      base1_d = base1_q;
      pp_d    = pp_q;
      buf_d   = buf_q;
      col_d   = col_q;
      line_d  = line_q;
      lbase_d = lbase_q;
      bw_d    = bw_q;
      irq_d   = irq_q;
      r_ack   = 1'b0;
      err_irq = 1'b0;
      // A start edge wins in every state, cutting any in-flight word without r_ack
      if (new_addr) begin
         base0_d = cfg_addr0;
         base1_d = cfg_addr1;
         pp_d    = cfg_ctrl[1];
         buf_d   = 1'b0;
         col_d   = '0;
         line_d  = '0;
         lbase_d = '0;
         bw_d    = '0;
         state_d = S_WAIT_PACK;
      end else begin
         case (state_q)
            S_WAIT_PACK: begin
               if (abort)                  state_d = S_IDLE;
               else if (nb_pack_available) state_d = S_WRITE;
            end
            S_WRITE: begin
               if (p_wb_ERR_I) begin
                  err_irq = 1'b1;
                  state_d = S_ERROR;
               end else if (p_wb_ACK_I) begin
                  r_ack = 1'b1;
                  bw_d  = (bw_q == BW_LAST) ? '0 : bw_q + 1'b1;
                  if (col_q == COL_LAST) begin
                     col_d   = '0;
                     line_d  = line_q + 1'b1;
                     lbase_d = lbase_q + 32'(STRIDE);
                  end else begin
                     col_d = col_q + COL_W'(4);
                  end
                  if (abort) begin
                     state_d = S_IDLE;
                  end else if (col_q == COL_LAST && line_q == LINE_LAST) begin
                     state_d = S_FRAME_DONE;
                     irq_d   = IRQ_LOAD;
                  end else if (bw_q == BW_LAST) begin
                     state_d = S_WAIT_PACK;
                  end else begin
                     state_d = S_BREAK;
                  end
               end
            end
            S_BREAK: state_d = abort ? S_IDLE : S_WRITE;
            S_FRAME_DONE: begin
               if (abort) begin
                  state_d = S_IDLE;
               end else if (irq_q == 4'd0) begin
                  if (pp_q) begin
                     buf_d   = ~buf_q;
                     col_d   = '0;
                     line_d  = '0;
                     lbase_d = '0;
                     bw_d    = '0;
                     state_d = S_WAIT_PACK;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  irq_d = irq_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_video_in_dma.sv
// tb/tb_video_in_dma.sv - Randomized bench for video_in_dma with an address-queue frame model.
module tb_video_in_dma;
   localparam int W = 8, H = 2, NP = 8, STR = 16, IRQ = 3, BUD = 3000;

   typedef struct {
      logic [31:0] adr;
      logic        bidx;
      bit          first;
   } exp_t;

   logic        clk = 1'b0;
   logic        nRST;
   logic [31:0] cfg_ctrl, cfg_addr0, cfg_addr1, data_fifo;
   logic        nb_pack_available;
   logic        r_ack, interrupt, err_irq, buf_idx, busy, new_addr;

   video_in_dma_if wb();

   int   n_pass = 0, n_chk = 0;
   int   wr_cnt = 0, err_cnt = 0, irq_done = 0, irq_run = 0;
   int   avail_pct = 100, lat_min = 0, lat_max = 0, err_arm = 0;
   bit   stb_prev = 0, avail_prev = 0, ctrl0_prev = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   video_in_dma #(.WIDTH(W), .HEIGHT(H), .NB_PACK(NP), .STRIDE(STR), .IRQ_LEN(IRQ)) dut (
      .clk(clk), .nRST(nRST), .cfg_ctrl(cfg_ctrl), .cfg_addr0(cfg_addr0), .cfg_addr1(cfg_addr1),
      .nb_pack_available(nb_pack_available), .data_fifo(data_fifo), .r_ack(r_ack),
      .interrupt(interrupt), .err_irq(err_irq), .buf_idx(buf_idx), .busy(busy), .new_addr(new_addr),
      .p_wb_STB_O(wb.stb), .p_wb_CYC_O(wb.cyc), .p_wb_LOCK_O(wb.lock), .p_wb_WE_O(wb.we),
      .p_wb_SEL_O(wb.sel), .p_wb_ADR_O(wb.adr), .p_wb_DAT_O(wb.dat),
      .p_wb_ACK_I(wb.ack), .p_wb_ERR_I(wb.err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   // Expected frame: every word address is base + line*STRIDE + col, computed directly
   task automatic push_frame(input logic [31:0] base, input logic bidx);
      for (int l = 0; l < H; l++)
         for (int c = 0; c < W; c += 4)
            q.push_back('{base + 32'(l * STR) + 32'(c), bidx, (c % NP) == 0});
   endtask

   function automatic bit cond_met(input int kind, input int target);
      case (kind)
         0: return wr_cnt >= target;
         1: return irq_done >= target;
         2: return err_cnt >= target;
         3: return busy == 1'b0;
         default: return wb.stb == 1'b1;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int kind, input int target);
      int n = 0;
      while (!cond_met(kind, target) && n < BUD) begin
         @(negedge clk); #1;
         n++;
      end
      check_eq(tag, {31'b0, cond_met(kind, target)}, 32'd1);
   endtask

   task automatic start(input bit pp);
      @(posedge clk); #1 cfg_ctrl = {29'b0, 1'b0, pp, 1'b1};
      @(posedge clk); #1 cfg_ctrl[0] = 1'b0;
   endtask

   task automatic abort_stop();
      @(posedge clk); #1 cfg_ctrl[2] = 1'b1;
      wait_for("abort_idle", 3, 0);
      cfg_ctrl[2] = 1'b0;
   endtask

   // Wishbone slave and FIFO source
   initial begin
      int lat = 0;
      wb.ack = 1'b0; wb.err = 1'b0; data_fifo = '0; nb_pack_available = 1'b0;
      forever begin
         @(posedge clk); #1;
         data_fifo = $urandom;
         nb_pack_available = ($urandom_range(0, 99) < avail_pct);
         if (!wb.stb || wb.ack || wb.err) begin
            wb.ack = 1'b0; wb.err = 1'b0;
            lat = $urandom_range(lat_min, lat_max);
         end else if (lat == 0) begin
            if (err_arm != 0) begin wb.err = 1'b1; err_arm = 0; end
            else wb.ack = 1'b1;
         end else begin
            lat--;
         end
      end
   end

   // Protocol monitor and scoreboard
   always @(negedge clk) begin
      bit edge_e, exp_rack, exp_err;
      edge_e   = cfg_ctrl[0] && !ctrl0_prev;
      exp_rack = wb.stb && wb.ack && !wb.err && !edge_e;
      exp_err  = wb.stb && wb.err && !edge_e;
      check_eq("new_addr", {31'b0, new_addr}, {31'b0, edge_e});
      check_eq("sel", {28'b0, wb.sel}, 32'hF);
      check_eq("we_lock", {30'b0, wb.we, wb.lock}, 32'd2);
      check_eq("dat", wb.dat, data_fifo);
      check_eq("r_ack", {31'b0, r_ack}, {31'b0, exp_rack});
      check_eq("err_irq", {31'b0, err_irq}, {31'b0, exp_err});
      if (wb.stb) check_eq("cyc_with_stb", {31'b0, wb.cyc}, 32'd1);
      if (wb.stb && !stb_prev && q.size() > 0 && q[0].first)
         check_eq("avail_before_burst", {31'b0, avail_prev}, 32'd1);
      if (exp_rack || exp_err) begin
         if (q.size() == 0) begin
            check_eq("stb_without_expected_word", {31'b0, wb.stb}, 32'd0);
         end else begin
            check_eq("adr", wb.adr, q[0].adr);
            check_eq("buf_idx", {31'b0, buf_idx}, {31'b0, q[0].bidx});
            if (exp_rack) begin void'(q.pop_front()); wr_cnt++; end
            else err_cnt++;
         end
      end
      if (interrupt) begin
         irq_run++;
      end else if (irq_run > 0) begin
         check_eq("irq_len", irq_run, IRQ);
         irq_done++;
         irq_run = 0;
      end
      stb_prev   = wb.stb;
      avail_prev = nb_pack_available;
      ctrl0_prev = cfg_ctrl[0];
   end

   initial begin
      int t;
      logic [31:0] b0, b1;
      bit pp;
      nRST = 1'b0; cfg_ctrl = '0; cfg_addr0 = '0; cfg_addr1 = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_outs", {26'b0, r_ack, interrupt, err_irq, busy, wb.stb, wb.cyc}, 32'd0);
      check_eq("rst_adr", wb.adr, 32'd0);
      check_eq("rst_buf", {31'b0, buf_idx}, 32'd0);
      nRST = 1'b1;
      repeat (2) @(negedge clk);

      // single frame
      cfg_addr0 = 32'h1000; cfg_addr1 = 32'h2000;
      push_frame(32'h1000, 1'b0);
      t = wr_cnt + 4;
      start(1'b0);
      wait_for("single_irq", 1, irq_done + 1);
      wait_for("single_idle", 3, 0);
      check_eq("single_words", wr_cnt, t);
      check_eq("single_q_empty", q.size(), 0);

      // ping-pong: 0x1000, 0x2000, 0x1000, then abort during the 4th frame
      push_frame(32'h1000, 1'b0); push_frame(32'h2000, 1'b1);
      push_frame(32'h1000, 1'b0); push_frame(32'h2000, 1'b1);
      start(1'b1);
      wait_for("pp_irq", 1, irq_done + 3);
      abort_stop();
      q.delete();

      // bus error on the second word, then restart
      push_frame(32'h1000, 1'b0);
      start(1'b0);
      wait_for("err_word0", 0, wr_cnt + 1);
      err_arm = 1;
      wait_for("err_seen", 2, err_cnt + 1);
      @(negedge clk);
      check_eq("err_after", {27'b0, wb.stb, wb.cyc, busy, err_irq, interrupt}, 32'd0);
      q.delete();
      push_frame(32'h1000, 1'b0);
      start(1'b0);
      wait_for("err_restart_irq", 1, irq_done + 1);
      wait_for("err_restart_idle", 3, 0);
      check_eq("err_restart_q", q.size(), 0);

      // backpressure between bursts
      push_frame(32'h1000, 1'b0);
      start(1'b0);
      wait_for("bp_burst0", 0, wr_cnt + 2);
      avail_pct = 0;
      repeat (10) begin
         @(negedge clk);
         check_eq("bp_idle_bus", {29'b0, wb.stb, wb.cyc, r_ack}, 32'd0);
      end
      avail_pct = 100;
      wait_for("bp_irq", 1, irq_done + 1);
      wait_for("bp_idle", 3, 0);
      check_eq("bp_q", q.size(), 0);

      // abort while waiting for a pack
      avail_pct = 0;
      start(1'b0);
      @(negedge clk);
      check_eq("abort_busy_before", {31'b0, busy}, 32'd1);
      @(posedge clk); #1 cfg_ctrl[2] = 1'b1;
      @(negedge clk);
      check_eq("abort_busy_same", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check_eq("abort_idle_next", {30'b0, busy, wb.stb}, 32'd0);
      cfg_ctrl[2] = 1'b0;
      avail_pct = 100;

      // start edge in the middle of a WRITE
      lat_min = 3; lat_max = 3;
      push_frame(32'h1000, 1'b0);
      start(1'b0);
      wait_for("mid_word0", 0, wr_cnt + 1);
      @(negedge clk); #1;
      wait_for("mid_stb", 4, 0);
      @(posedge clk); #1;
      q.delete();
      push_frame(32'h1000, 1'b0);
      cfg_ctrl[0] = 1'b1;
      @(negedge clk);
      check_eq("mid_in_write", {31'b0, wb.stb}, 32'd1);
      @(posedge clk); #1 cfg_ctrl[0] = 1'b0;
      lat_min = 0; lat_max = 0;
      wait_for("mid_irq", 1, irq_done + 1);
      wait_for("mid_idle", 3, 0);
      check_eq("mid_q", q.size(), 0);

      // asynchronous reset during a WRITE
      lat_min = 3; lat_max = 3;
      push_frame(32'h1000, 1'b0);
      start(1'b0);
      wait_for("rst_stb", 4, 0);
      #2 nRST = 1'b0;
      #1;
      check_eq("rst_mid_outs", {26'b0, r_ack, interrupt, err_irq, busy, wb.stb, wb.cyc}, 32'd0);
      check_eq("rst_mid_adr", wb.adr, 32'd0);
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      q.delete();
      lat_min = 0; lat_max = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_release_idle", {30'b0, busy, wb.cyc}, 32'd0);

      // randomized frames
      for (int it = 0; it < 6; it++) begin
         b0 = (it == 0) ? 32'hFFFF_FFF8 : $urandom;
         b1 = $urandom;
         pp = 1'($urandom_range(0, 1));
         avail_pct = $urandom_range(30, 100);
         lat_max = $urandom_range(0, 3);
         cfg_addr0 = b0; cfg_addr1 = b1;
         for (int f = 0; f < (pp ? 4 : 1); f++)
            push_frame((f % 2) ? b1 : b0, 1'(f % 2));
         start(pp);
         wait_for("rnd_irq", 1, irq_done + (pp ? 3 : 1));
         if (pp) begin
            abort_stop();
         end else begin
            wait_for("rnd_idle", 3, 0);
            check_eq("rnd_q", q.size(), 0);
         end
         q.delete();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
